// File: rtl/canv_draw_agu_pkg.sv
// Shared graphics definitions for the canvas address generation units
// (draw and display side): machine word size, log2 helper and pixel masks.
package canv_draw_agu_pkg;

  // Default machine word size in bits.
  localparam int GFX_WORD     = 32;

  // Widest word the mask helper can describe.
  localparam int GFX_MAX_WORD = 64;

  // log2 of a power-of-two word size; usable in constant expressions.
  function automatic int word_log2(input int word);
    return $clog2(word);
  endfunction

  // Mask with the low bpp bits set; bpp at or above GFX_MAX_WORD gives all ones.
  function automatic logic [GFX_MAX_WORD-1:0] bpp_mask(input int unsigned bpp);
    logic [GFX_MAX_WORD-1:0] m;
    if (bpp >= GFX_MAX_WORD) begin
      m = '1;
    end else begin
      m = (GFX_MAX_WORD'(1) << bpp) - GFX_MAX_WORD'(1);
    end
    return m;
  endfunction

  // Address shifts beyond log2(word) mean less than one bit per pixel; pin
  // them to 1 bpp.
  function automatic int unsigned clamp_shift(input int unsigned shift,
                                              input int unsigned log2w);
    return (shift > log2w) ? log2w : shift;
  endfunction

endpackage

// File: rtl/canv_draw_agu_if.sv
// Draw request channel plus VRAM write channel of the canvas draw AGU.
// The master modport is the AGU view: it accepts draw requests and drives VRAM
// writes. The slave modport is the surrounding system: the drawing engines and
// the VRAM write port.
interface canv_draw_agu_if
  import canv_draw_agu_pkg::*;
#(
  parameter int CORDW   = 16,
  parameter int WORD    = GFX_WORD,
  parameter int ADDRW   = 16,
  parameter int PIX_IDW = $clog2(WORD)
);

  // Draw request channel.
  logic                    s_valid;
  logic                    s_ready;
  logic signed [CORDW-1:0] x;
  logic signed [CORDW-1:0] y;
  logic [WORD-1:0]         colour;

  // VRAM write channel.
  logic                    m_valid;
  logic                    m_ready;
  logic [ADDRW-1:0]        m_addr;
  logic [PIX_IDW-1:0]      m_pix_id;
  logic [WORD-1:0]         m_mask;
  logic [WORD-1:0]         m_data;

  modport master (
    input  s_valid, x, y, colour, m_ready,
    output s_ready, m_valid, m_addr, m_pix_id, m_mask, m_data
  );

  modport slave (
    output s_valid, x, y, colour, m_ready,
    input  s_ready, m_valid, m_addr, m_pix_id, m_mask, m_data
  );

endinterface

// File: rtl/canv_draw_agu_lane_mask.sv
// Pixel lane helper: turns a (clamped) address shift and pixel ID into the
// bit-lane write mask and the colour aligned into that lane. Purely
// combinational.
module canv_draw_agu_lane_mask
  import canv_draw_agu_pkg::*;
#(
  parameter int WORD    = GFX_WORD,
  parameter int PIX_IDW = $clog2(WORD),
  parameter int SW      = $clog2(word_log2(WORD) + 1)
) (
  input  logic [SW-1:0]      shift,
  input  logic [PIX_IDW-1:0] pix_id,
  input  logic [WORD-1:0]    colour,
  output logic [WORD-1:0]    mask,
  output logic [WORD-1:0]    data
);

  localparam int LOG2W = word_log2(WORD);

  logic [WORD-1:0]  pix_mask;
  logic [LOG2W-1:0] offset;

  // bpp = WORD >> shift; pixel n of a word occupies bits [n*bpp +: bpp].
  always_comb begin
    pix_mask = WORD'(bpp_mask(WORD >> shift));
    offset   = LOG2W'(pix_id << (LOG2W - int'(shift)));
    mask     = pix_mask << offset;
    data     = (colour & pix_mask) << offset;
  end

endmodule

// File: rtl/canv_draw_agu.sv
// Canvas draw address generation unit. Takes signed pixel draw requests from
// the drawing engines, discards those outside the canvas, and emits VRAM word
// writes (word address, pixel ID, lane mask, lane-aligned data) through a
// three-stage pipeline that stalls as a whole on VRAM backpressure.
module canv_draw_agu
  import canv_draw_agu_pkg::*;
#(
  parameter int CORDW   = 16,
  parameter int WORD    = GFX_WORD,
  parameter int ADDRW   = 16,
  parameter int PIX_IDW = $clog2(WORD),
  parameter int SHIFTW  = 3
) (
  input  logic              clk_sys,
  input  logic              rst_sys_n,
  input  logic [ADDRW-1:0]  addr_base,
  input  logic [SHIFTW-1:0] addr_shift,
  input  logic [CORDW-1:0]  canv_w,
  input  logic [CORDW-1:0]  canv_h,
  canv_draw_agu_if.master   bus,
  output logic              clip,
  output logic              busy
);

  localparam int LOG2W = word_log2(WORD);
  localparam int SW    = $clog2(LOG2W + 1);
  localparam int IDXW  = ADDRW + PIX_IDW;

  // Handshake and request qualification.
  logic              stall;
  logic              adv;
  logic              accept;
  logic              clip_now;
  logic [SW-1:0]     shift_c;

  // Stage valids; vld_p2 is the VRAM write valid.
  logic              vld_p0;
  logic              vld_p1;
  logic              vld_p2;

  // Stage 1 payload: registered product, x and the config sampled at accept.
  logic [IDXW-1:0]   prod_p0;
  logic [CORDW-1:0]  x_p0;
  logic [ADDRW-1:0]  base_p0;
  logic [SW-1:0]     shift_p0;
  logic [WORD-1:0]   colour_p0;

  // Stage 2 payload: linear pixel index.
  logic [IDXW-1:0]   idx_p1;
  logic [ADDRW-1:0]  base_p1;
  logic [SW-1:0]     shift_p1;
  logic [WORD-1:0]   colour_p1;

  // Stage 3 combinational lane results.
  logic [PIX_IDW-1:0] pix_id_c;
  logic [WORD-1:0]    mask_c;
  logic [WORD-1:0]    data_c;

  // The whole pipe freezes while the output word is waiting; bubbles are kept.
  assign stall       = vld_p2 & ~bus.m_ready;
  assign adv         = ~stall;
  assign bus.s_ready = adv;
  assign accept      = bus.s_valid & adv;

  // Coordinates are signed; the canvas size is unsigned. After the sign bits
  // are excluded, an unsigned compare matches the zero-extended signed one.
  assign clip_now = bus.x[CORDW-1] | bus.y[CORDW-1] |
                    ($unsigned(bus.x) >= canv_w) |
                    ($unsigned(bus.y) >= canv_h);

  assign shift_c     = SW'(clamp_shift(int'(addr_shift), LOG2W));
  assign busy        = vld_p0 | vld_p1 | vld_p2;
  assign bus.m_valid = vld_p2;

  // Stage valids advance together; clipped requests never enter the pipe and
  // instead raise a one-cycle clip pulse.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      clip   <= 1'b0;
    end else begin
      clip <= accept & clip_now;
      if (adv) begin
        vld_p0 <= accept & ~clip_now;
        vld_p1 <= vld_p0;
        vld_p2 <= vld_p1;
      end
    end
  end

  // ---- S1: row product y*canv_w and config captured at acceptance ----
  always_ff @(posedge clk_sys) begin
    if (adv) begin
      prod_p0   <= IDXW'($unsigned(bus.y) * canv_w);
      x_p0      <= $unsigned(bus.x);
      base_p0   <= addr_base;
      shift_p0  <= shift_c;
      colour_p0 <= bus.colour;
    end
  end

  // ---- S2: linear pixel index, wrapping modulo 2^(ADDRW+PIX_IDW) ----
  always_ff @(posedge clk_sys) begin
    if (adv) begin
      idx_p1    <= prod_p0 + IDXW'(x_p0);
      base_p1   <= base_p0;
      shift_p1  <= shift_p0;
      colour_p1 <= colour_p0;
    end
  end

  // ---- S3: word address, pixel ID and lane placement ----
  assign pix_id_c = PIX_IDW'(idx_p1) & PIX_IDW'((IDXW'(1) << shift_p1) - IDXW'(1));

  canv_draw_agu_lane_mask #(
    .WORD    (WORD),
    .PIX_IDW (PIX_IDW),
    .SW      (SW)
  ) u_lane_mask (
    .shift   (shift_p1),
    .pix_id  (pix_id_c),
    .colour  (colour_p1),
    .mask    (mask_c),
    .data    (data_c)
  );

  // Output word register; holds its value while the VRAM port stalls.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      bus.m_addr   <= '0;
      bus.m_pix_id <= '0;
      bus.m_mask   <= '0;
      bus.m_data   <= '0;
    end else if (adv && vld_p1) begin
      bus.m_addr   <= base_p1 + ADDRW'(idx_p1 >> shift_p1);
      bus.m_pix_id <= pix_id_c;
      bus.m_mask   <= mask_c;
      bus.m_data   <= data_c;
    end
  end

endmodule

// File: tb/tb_canv_draw_agu.sv
// Directed bench for canv_draw_agu: pixel formats, clipping, backpressure,
// per-request config and reset with requests in flight.
module tb_canv_draw_agu;

  localparam int CORDW = 16, WORD = 32, ADDRW = 16, PIX_IDW = 5, SHIFTW = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDRW-1:0]  addr_base;
  logic [SHIFTW-1:0] addr_shift;
  logic [CORDW-1:0]  canv_w, canv_h;
  logic              clip, busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] ga [8];
  logic [4:0]  gp [8];
  logic [31:0] gm [8];
  logic [31:0] gd [8];
  logic        gv [8];

  canv_draw_agu_if #(.CORDW(CORDW), .WORD(WORD), .ADDRW(ADDRW), .PIX_IDW(PIX_IDW)) bus ();

  canv_draw_agu #(
    .CORDW(CORDW), .WORD(WORD), .ADDRW(ADDRW), .PIX_IDW(PIX_IDW), .SHIFTW(SHIFTW)
  ) dut (
    .clk_sys    (clk),
    .rst_sys_n  (rst_n),
    .addr_base  (addr_base),
    .addr_shift (addr_shift),
    .canv_w     (canv_w),
    .canv_h     (canv_h),
    .bus        (bus),
    .clip       (clip),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one request for one cycle; call #1 after a rising edge.
  task automatic drive_req(input logic signed [15:0] xi, input logic signed [15:0] yi,
                           input logic [31:0] ci);
    bus.s_valid = 1'b1; bus.x = xi; bus.y = yi; bus.colour = ci;
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
  endtask

  // Wait (bounded) for m_valid; lat counts cycles from the request cycle.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!bus.m_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_one(input logic signed [15:0] xi, input logic signed [15:0] yi,
                         input logic [31:0] ci, output int lat, output logic [15:0] a,
                         output logic [4:0] p, output logic [31:0] mk, output logic [31:0] d);
    drive_req(xi, yi, ci);
    wait_out(lat);
    a = bus.m_addr; p = bus.m_pix_id; mk = bus.m_mask; d = bus.m_data;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.s_valid = 1'b0; bus.m_ready = 1'b1; bus.x = '0; bus.y = '0; bus.colour = '0;
    addr_base = '0; addr_shift = '0; canv_w = 16'd320; canv_h = 16'd240;
    repeat (2) @(posedge clk); #1;
    checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b exp 0", bus.m_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (clip !== 1'b0) begin errors++; $display("FAIL reset_clip got %b exp 0", clip); end
    checks++; if (bus.m_addr !== 16'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", bus.m_addr); end
    checks++; if (bus.m_pix_id !== 5'h0) begin errors++; $display("FAIL reset_pix got %h exp 0", bus.m_pix_id); end
    checks++; if (bus.m_mask !== 32'h0) begin errors++; $display("FAIL reset_mask got %h exp 0", bus.m_mask); end
    checks++; if (bus.m_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", bus.m_data); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_8bpp();
    int lat; logic [15:0] a; logic [4:0] p; logic [31:0] mk, d;
    addr_base = 16'h1000; addr_shift = 3'd2; canv_w = 16'd320; canv_h = 16'd240;
    run_one(16'sd5, 16'sd2, 32'hAB, lat, a, p, mk, d);
    checks++; if (lat != 3) begin errors++; $display("FAIL bpp8_latency got %0d exp 3", lat); end
    checks++; if (a !== 16'h10A1) begin errors++; $display("FAIL bpp8_addr got %h exp 10a1", a); end
    checks++; if (p !== 5'd1) begin errors++; $display("FAIL bpp8_pix got %0d exp 1", p); end
    checks++; if (mk !== 32'h0000FF00) begin errors++; $display("FAIL bpp8_mask got %h exp 0000ff00", mk); end
    checks++; if (d !== 32'h0000AB00) begin errors++; $display("FAIL bpp8_data got %h exp 0000ab00", d); end
    checks++; if (bus.m_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bpp8_drain got valid %b busy %b exp 0 0", bus.m_valid, busy); end
  endtask

  task automatic test_1bpp_clamp();
    int lat; logic [15:0] a; logic [4:0] p; logic [31:0] mk, d;
    addr_base = 16'h0000; addr_shift = 3'd5;
    run_one(16'sd33, 16'sd0, 32'hFF, lat, a, p, mk, d);
    checks++; if (a !== 16'h0001) begin errors++; $display("FAIL bpp1_addr got %h exp 0001", a); end
    checks++; if (p !== 5'd1) begin errors++; $display("FAIL bpp1_pix got %0d exp 1", p); end
    checks++; if (mk !== 32'h2 || d !== 32'h2) begin errors++; $display("FAIL bpp1_mask_data got %h %h exp 2 2", mk, d); end
    addr_shift = 3'd7;
    run_one(16'sd33, 16'sd0, 32'hFF, lat, a, p, mk, d);
    checks++; if (a !== 16'h0001 || p !== 5'd1) begin errors++; $display("FAIL clamp_addr_pix got %h %0d exp 0001 1", a, p); end
    checks++; if (mk !== 32'h2 || d !== 32'h2) begin errors++; $display("FAIL clamp_mask_data got %h %h exp 2 2", mk, d); end
  endtask

  task automatic test_32bpp();
    int lat; logic [15:0] a; logic [4:0] p; logic [31:0] mk, d;
    addr_base = 16'h2000; addr_shift = 3'd0;
    run_one(16'sd0, 16'sd0, 32'hDEADBEEF, lat, a, p, mk, d);
    checks++; if (a !== 16'h2000 || p !== 5'd0) begin errors++; $display("FAIL bpp32_addr_pix got %h %0d exp 2000 0", a, p); end
    checks++; if (mk !== 32'hFFFFFFFF) begin errors++; $display("FAIL bpp32_mask got %h exp ffffffff", mk); end
    checks++; if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL bpp32_data got %h exp deadbeef", d); end
  endtask

  task automatic test_edges();
    int lat; logic [15:0] a; logic [4:0] p; logic [31:0] mk, d;
    addr_shift = 3'd2;
    addr_base = 16'hFFFF;
    run_one(16'sd8, 16'sd0, 32'h123456C3, lat, a, p, mk, d);
    checks++; if (a !== 16'h0001 || p !== 5'd0) begin errors++; $display("FAIL wrap_addr_pix got %h %0d exp 0001 0", a, p); end
    checks++; if (mk !== 32'h000000FF || d !== 32'h000000C3) begin errors++; $display("FAIL wrap_mask_data got %h %h exp 000000ff 000000c3", mk, d); end
    addr_base = 16'h0000;
    run_one(16'sd319, 16'sd239, 32'h12, lat, a, p, mk, d);
    checks++; if (a !== 16'h4AFF || p !== 5'd3) begin errors++; $display("FAIL corner_addr_pix got %h %0d exp 4aff 3", a, p); end
    checks++; if (mk !== 32'hFF000000 || d !== 32'h12000000) begin errors++; $display("FAIL corner_mask_data got %h %h exp ff000000 12000000", mk, d); end
  endtask

  task automatic test_clip();
    logic signed [15:0] cx [4];
    logic signed [15:0] cy [4];
    int pulses, seen;
    cx[0] = -16'sd1; cy[0] = 16'sd0;
    cx[1] = 16'sd320; cy[1] = 16'sd0;
    cx[2] = 16'sd0;   cy[2] = 16'sd240;
    cx[3] = 16'sd0;   cy[3] = -16'sd1;
    addr_base = 16'h1000; addr_shift = 3'd2; canv_w = 16'd320; canv_h = 16'd240;
    for (int k = 0; k < 4; k++) begin
      drive_req(cx[k], cy[k], 32'h55);
      checks++; if (clip !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL clip%0d_pulse got clip %b busy %b exp 1 0", k, clip, busy); end
      pulses = 0; seen = 0;
      for (int i = 0; i < 5; i++) begin
        @(posedge clk); #1;
        if (clip) pulses++;
        if (bus.m_valid) seen++;
      end
      checks++; if (pulses != 0) begin errors++; $display("FAIL clip%0d_extra_pulses got %0d exp 0", k, pulses); end
      checks++; if (seen != 0) begin errors++; $display("FAIL clip%0d_write got %0d exp 0", k, seen); end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [31:0] exp_d [4];
    exp_d[0] = 32'h00000011; exp_d[1] = 32'h00002200; exp_d[2] = 32'h00330000; exp_d[3] = 32'h44000000;
    addr_base = 16'h1000; addr_shift = 3'd2;
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b1; bus.x = 16'sd0; bus.y = 16'sd0; bus.colour = 32'h11;
    @(posedge clk); #1; bus.x = 16'sd1; bus.colour = 32'h22;
    @(posedge clk); #1; bus.x = 16'sd2; bus.colour = 32'h33;
    @(posedge clk); #1; bus.x = 16'sd3; bus.colour = 32'h44;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL stall%0d_s_ready got %b exp 0", i, bus.s_ready); end
      checks++; if (bus.m_valid !== 1'b1) begin errors++; $display("FAIL stall%0d_m_valid got %b exp 1", i, bus.m_valid); end
      checks++; if (bus.m_addr !== 16'h1000 || bus.m_pix_id !== 5'd0 || bus.m_data !== 32'h11) begin
        errors++; $display("FAIL stall%0d_hold got %h %0d %h exp 1000 0 00000011", i, bus.m_addr, bus.m_pix_id, bus.m_data);
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 8; i++) begin ga[i] = '0; gp[i] = '0; gd[i] = '0; end
    bus.m_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.m_valid && n < 8) begin ga[n] = bus.m_addr; gp[n] = bus.m_pix_id; gd[n] = bus.m_data; n++; end
      @(posedge clk); #1;
      bus.s_valid = 1'b0;
    end
    checks++; if (n != 4) begin errors++; $display("FAIL b2b_count got %0d exp 4", n); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (ga[i] !== 16'h1000 || gp[i] !== 5'(i) || gd[i] !== exp_d[i]) begin
        errors++; $display("FAIL b2b_word%0d got %h %0d %h exp 1000 %0d %h", i, ga[i], gp[i], gd[i], i, exp_d[i]);
      end
    end
  endtask

  task automatic test_stream_cfg();
    bus.m_ready = 1'b1;
    addr_base = 16'h1000; addr_shift = 3'd2;
    bus.s_valid = 1'b1; bus.x = 16'sd4; bus.y = 16'sd0; bus.colour = 32'h5A;
    @(posedge clk); #1; addr_base = 16'h3000; addr_shift = 3'd3;
    @(posedge clk); #1; addr_base = 16'h1000; addr_shift = 3'd2; bus.x = 16'sd6; bus.colour = 32'h77;
    @(posedge clk); #1; bus.s_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      gv[i] = bus.m_valid; ga[i] = bus.m_addr; gp[i] = bus.m_pix_id; gm[i] = bus.m_mask; gd[i] = bus.m_data;
      @(posedge clk); #1;
    end
    checks++; if ({gv[0], gv[1], gv[2], gv[3]} !== 4'b1110) begin errors++; $display("FAIL stream_valid got %b%b%b%b exp 1110", gv[0], gv[1], gv[2], gv[3]); end
    checks++; if (ga[0] !== 16'h1001 || gp[0] !== 5'd0 || gm[0] !== 32'h000000FF || gd[0] !== 32'h0000005A) begin
      errors++; $display("FAIL stream_w0 got %h %0d %h %h exp 1001 0 000000ff 0000005a", ga[0], gp[0], gm[0], gd[0]);
    end
    checks++; if (ga[1] !== 16'h3000 || gp[1] !== 5'd4 || gm[1] !== 32'h000F0000 || gd[1] !== 32'h000A0000) begin
      errors++; $display("FAIL stream_w1 got %h %0d %h %h exp 3000 4 000f0000 000a0000", ga[1], gp[1], gm[1], gd[1]);
    end
    checks++; if (ga[2] !== 16'h1001 || gp[2] !== 5'd2 || gm[2] !== 32'h00FF0000 || gd[2] !== 32'h00770000) begin
      errors++; $display("FAIL stream_w2 got %h %0d %h %h exp 1001 2 00ff0000 00770000", ga[2], gp[2], gm[2], gd[2]);
    end
  endtask

  task automatic test_reset_midflight();
    int seen;
    addr_base = 16'h1000; addr_shift = 3'd2;
    bus.m_ready = 1'b0;
    bus.s_valid = 1'b1; bus.x = 16'sd0; bus.y = 16'sd1; bus.colour = 32'h99;
    @(posedge clk); #1; bus.x = 16'sd1;
    @(posedge clk); #1; bus.x = 16'sd2;
    @(posedge clk); #1; bus.s_valid = 1'b0;
    checks++; if (bus.m_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL inflight_pre got valid %b busy %b exp 1 1", bus.m_valid, busy); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.m_valid !== 1'b0 || busy !== 1'b0 || clip !== 1'b0) begin
      errors++; $display("FAIL inflight_rst got valid %b busy %b clip %b exp 0 0 0", bus.m_valid, busy, clip);
    end
    checks++; if (bus.m_addr !== 16'h0 || bus.m_data !== 32'h0 || bus.m_mask !== 32'h0) begin
      errors++; $display("FAIL inflight_rst_data got %h %h %h exp 0 0 0", bus.m_addr, bus.m_data, bus.m_mask);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; bus.m_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.m_valid || busy) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL inflight_stale got %0d exp 0", seen); end
  endtask

  initial begin
    test_reset();
    test_8bpp();
    test_1bpp_clamp();
    test_32bpp();
    test_edges();
    test_clip();
    test_back_to_back();
    test_stream_cfg();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
